muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_if.sv | 26 ++
 rtl/muldiv_seq.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake and result bus for the sequential multiply/divide unit.
// master drives requests; slave (the unit) returns status and results.
interface muldiv_seq_if #(
   parameter int WORD = 8
);
   logic            start;
   logic            op;        // 0 = multiply, 1 = divide
   logic            sign;      // 1 = two's-complement operands
   logic [WORD-1:0] a;
   logic [WORD-1:0] b;
   logic            busy;
   logic            done;
   logic [WORD-1:0] r;
   logic [WORD-1:0] r_high;
   logic            div_zero;

   modport master (
      output start, op, sign, a, b,
      input  busy, done, r, r_high, div_zero
   );

   modport slave (
      input  start, op, sign, a, b,
      output busy, done, r, r_high, div_zero
   );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential multiply / divide unit.
// Multiply: radix-2 shift-add on operand magnitudes, WORD steps.
// Divide: restoring shift-subtract on operand magnitudes, WORD steps.
// Signs are stripped on capture and re-applied when the result is registered,
// so the datapath itself is purely unsigned.
// Timeline for a start sampled at edge E0: CALC steps on edges E0+1..E0+WORD,
// the counter sits at zero for one cycle, and DONE is entered on E0+WORD+1
// with r/r_high/div_zero/done all registered on that same edge.
module muldiv_seq #(
   parameter int WORD = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   muldiv_seq_if.slave bus
);

   localparam int CW = $clog2(WORD + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;

   // captured request
   logic            op_q;
   logic            bz_q;      // divisor was zero
   logic            neg_ab;    // product / quotient is negative
   logic            neg_a;     // remainder takes sign of dividend
   logic [WORD-1:0] a_q;       // raw dividend, returned on divide-by-zero
   logic [WORD-1:0] mb_q;      // |b|

   // working registers: hi = partial product high / partial remainder,
   // lo = multiplier being shifted out / dividend shifted into quotient
   logic [WORD-1:0] hi;
   logic [WORD-1:0] lo;

   // registered outputs
   logic            busy_q;
   logic            done_q;
   logic [WORD-1:0] r_q;
   logic [WORD-1:0] rh_q;
   logic            dz_q;

   // operand magnitudes; the most-negative value maps to 2^(WORD-1),
   // which still fits as an unsigned WORD-bit magnitude
   logic [WORD-1:0] ma;
   logic [WORD-1:0] mb;

   // one iteration step
   logic [WORD:0]   sum;
   logic [WORD:0]   sh;
   logic [WORD:0]   diff;
   logic [WORD-1:0] hi_n;
   logic [WORD-1:0] lo_n;

   // sign-corrected final values
   logic [2*WORD-1:0] prod;
   logic [2*WORD-1:0] prod_s;
   logic [WORD-1:0]   quo_s;
   logic [WORD-1:0]   rem_s;
   logic [WORD-1:0]   fin_r;
   logic [WORD-1:0]   fin_rh;
   logic              fin_dz;

   assign ma = (bus.sign && bus.a[WORD-1]) ? -bus.a : bus.a;
   assign mb = (bus.sign && bus.b[WORD-1]) ? -bus.b : bus.b;

   // Next value of the working registers for one multiply or divide step.
   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, mb_q} : '0);
      sh   = {hi, lo[WORD-1]};
      diff = sh - {1'b0, mb_q};
      hi_n = hi;
      lo_n = lo;
      if (!op_q) begin
         // add-if-lsb, then shift the {carry,hi,lo} chain right
         hi_n = sum[WORD:1];
         lo_n = {sum[0], lo[WORD-1:1]};
      end else if (!diff[WORD]) begin
         // trial subtract fits: keep difference, quotient bit 1
         hi_n = diff[WORD-1:0];
         lo_n = {lo[WORD-2:0], 1'b1};
      end else begin
         // borrow: restore the shifted remainder, quotient bit 0
         hi_n = sh[WORD-1:0];
         lo_n = {lo[WORD-2:0], 1'b0};
      end
   end

   // Re-apply signs to the unsigned result and pick the result words.
   // Most-negative / -1 needs no special case: magnitude quotient is
   // 2^(WORD-1), positive sign, which truncates back to the dividend.
   always_comb begin
      prod   = {hi, lo};
      prod_s = neg_ab ? -prod : prod;
      quo_s  = neg_ab ? -lo : lo;
      rem_s  = neg_a ? -hi : hi;
      fin_r  = prod_s[WORD-1:0];
      fin_rh = prod_s[2*WORD-1:WORD];
      fin_dz = 1'b0;
      if (op_q) begin
         if (bz_q) begin
            fin_r  = '1;
            fin_rh = a_q;
            fin_dz = 1'b1;
         end else begin
            fin_r  = quo_s;
            fin_rh = rem_s;
         end
      end
   end

   // Control FSM with registered status/results; datapath iterates in CALC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= 1'b0;
         bz_q   <= 1'b0;
         neg_ab <= 1'b0;
         neg_a  <= 1'b0;
         a_q    <= '0;
         mb_q   <= '0;
         hi     <= '0;
         lo     <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         r_q    <= '0;
         rh_q   <= '0;
         dz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  op_q   <= bus.op;
                  bz_q   <= (bus.b == '0);
                  neg_ab <= bus.sign & (bus.a[WORD-1] ^ bus.b[WORD-1]);
                  neg_a  <= bus.sign & bus.a[WORD-1];
                  a_q    <= bus.a;
                  mb_q   <= mb;
                  hi     <= '0;
                  lo     <= ma;
                  cnt    <= CW'(WORD);
                  busy_q <= 1'b1;
                  state  <= CALC;
               end else begin
                  state  <= IDLE;
               end
            end
            CALC: begin
               // start is not looked at here, so requests while busy are dropped
               if (cnt != '0) begin
                  hi  <= hi_n;
                  lo  <= lo_n;
                  cnt <= cnt - CW'(1);
               end else begin
                  r_q    <= fin_r;
                  rh_q   <= fin_rh;
                  dz_q   <= fin_dz;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= DONE;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.r        = r_q;
   assign bus.r_high   = rh_q;
   assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq (WORD=8): expected results are queued when
// a request is driven and compared when done pulses.
module tb_muldiv_seq;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_err;

   typedef struct {
      logic [7:0] r;
      logic [7:0] rh;
      logic       dz;
      int         t0;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   muldiv_seq_if #(.WORD(8)) bus ();

   muldiv_seq #(.WORD(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic op, input logic sign,
                                  input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int   sa, sv, p, q, m;
      e.r  = '0;
      e.rh = '0;
      e.dz = 1'b0;
      e.t0 = 0;
      sa = sign ? int'($signed(a)) : int'(a);
      sv = sign ? int'($signed(b)) : int'(b);
      if (!op) begin
         p    = sa * sv;
         e.r  = p[7:0];
         e.rh = p[15:8];
      end else if (b == 8'h00) begin
         e.r  = 8'hFF;
         e.rh = a;
         e.dz = 1'b1;
      end else if (sign && sa == -128 && sv == -1) begin
         e.r  = a;
         e.rh = 8'h00;
      end else begin
         q    = sa / sv;
         m    = sa % sv;
         e.r  = q[7:0];
         e.rh = m[7:0];
      end
      return e;
   endfunction

   // compare every done pulse against the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("r", 32'(bus.r), 32'(mon_e.r));
            chk("r_high", 32'(bus.r_high), 32'(mon_e.rh));
            chk("div_zero", 32'(bus.div_zero), 32'(mon_e.dz));
            chk("latency", 32'(cyc - mon_e.t0), 32'd9);
         end
      end
   end

   task automatic drive(input logic op, input logic sign, input logic [7:0] a,
                        input logic [7:0] b, input bit expect_it);
      exp_t e;
      bus.start = 1'b1;
      bus.op    = op;
      bus.sign  = sign;
      bus.a     = a;
      bus.b     = b;
      if (expect_it) begin
         e    = model(op, sign, a, b);
         e.t0 = cyc + 1;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!bus.done && k < 30) begin
         @(negedge clk);
         k++;
      end
      if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_op(input logic op, input logic sign, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      drive(op, sign, a, b, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      @(negedge clk);
   endtask

   initial begin
      int   nb;
      logic [7:0] last_r;
      cyc = 0;
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.op = 1'b0;
      bus.sign = 1'b0;
      bus.a = '0;
      bus.b = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_r", 32'(bus.r), 32'd0);
      chk("rst_r_high", 32'(bus.r_high), 32'd0);
      chk("rst_div_zero", 32'(bus.div_zero), 32'd0);
      rst_n = 1'b1;

      // unsigned 200*3 with busy profile; start on the first edge out of reset
      drive(1'b0, 1'b0, 8'd200, 8'd3, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      nb = (bus.busy === 1'b1) ? 1 : 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) nb++;
         if (bus.done === 1'b1) chk("done_early", 32'd1, 32'd0);
      end
      chk("busy_cycles", 32'(nb), 32'd8);
      wait_done();
      @(negedge clk);
      chk("busy_after_done", 32'(bus.busy), 32'd0);

      // directed multiply / divide cases
      do_op(1'b0, 1'b1, 8'hFB, 8'd8);
      do_op(1'b0, 1'b0, 8'hFB, 8'd8);
      do_op(1'b1, 1'b0, 8'd65, 8'd4);
      do_op(1'b1, 1'b1, 8'hF9, 8'd2);
      do_op(1'b1, 1'b1, 8'd64, 8'hFC);
      do_op(1'b1, 1'b0, 8'h2A, 8'h00);
      do_op(1'b1, 1'b1, 8'h80, 8'hFF);
      do_op(1'b0, 1'b1, 8'h80, 8'h80);
      do_op(1'b0, 1'b0, 8'hFF, 8'hFF);

      // start during CALC with other operands must be dropped
      @(negedge clk);
      drive(1'b0, 1'b0, 8'd17, 8'd9, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      drive(1'b1, 1'b1, 8'h55, 8'h03, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      last_r = 8'(17 * 9);
      repeat (4) @(negedge clk);
      chk("r_hold", 32'(bus.r), 32'(last_r));
      repeat (12) @(negedge clk);

      // back-to-back: second start issued in the DONE cycle of the first
      @(negedge clk);
      drive(1'b0, 1'b1, 8'hF0, 8'h07, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      drive(1'b1, 1'b0, 8'd200, 8'd7, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      @(negedge clk);

      // reset in the middle of CALC aborts with no done pulse
      drive(1'b0, 1'b0, 8'd99, 8'd77, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_r", 32'(bus.r), 32'd0);
      chk("abort_r_high", 32'(bus.r_high), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      do_op(1'b1, 1'b1, 8'h81, 8'h10);

      // random mix
      for (int i = 0; i < 20; i++) begin
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
